// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked parametrised ALU with multi-cycle shift-add multiplier
module alu_seq #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             carry_out,
   output logic             overflow,
   output logic             negative,
   output logic             zero,
   output logic             busy
);

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_NOT = 4'd5;
   localparam logic [3:0] OP_SHL = 4'd6;
   localparam logic [3:0] OP_SHR = 4'd7;
   localparam logic [3:0] OP_MUL = 4'd8;
   localparam logic [3:0] OP_ASR = 4'd9;
   localparam logic [3:0] OP_ROL = 4'd10;
   localparam logic [3:0] OP_ROR = 4'd11;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DONE
   } state_t;

   state_t             state;
   logic [WIDTH-1:0]   a_r;
   logic [WIDTH-1:0]   acc_hi;
   logic [WIDTH-1:0]   acc_lo;
   logic [CNT_W-1:0]   cnt;

   logic [WIDTH-1:0]   c_res;
   logic               c_carry;
   logic               c_ovf;
   logic [WIDTH:0]     add_full;
   logic [WIDTH:0]     sub_full;
   logic [WIDTH:0]     mul_sum;
   logic               accept;

   // Gated by rst_n so in_ready reads 0 while reset is held.
   assign in_ready = rst_n && (state == S_IDLE);
   assign busy     = (state != S_IDLE);
   assign accept   = in_valid && in_ready;

   assign add_full = {1'b0, a} + {1'b0, b};
   assign sub_full = {1'b0, a} - {1'b0, b};
   // Partial product: add A into the high half when the current multiplier LSB is set.
   assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, a_r} : {(WIDTH + 1){1'b0}});

   // Single-cycle datapath evaluated on the presented operands at the accepting edge.
   always_comb begin
      c_res   = '0;
      c_carry = 1'b0;
      c_ovf   = 1'b0;
      case (op)
         OP_ADD: begin
            c_res   = add_full[WIDTH-1:0];
            c_carry = add_full[WIDTH];
            c_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (c_res[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            c_res   = sub_full[WIDTH-1:0];
            c_carry = sub_full[WIDTH];
            c_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (c_res[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND: c_res = a & b;
         OP_OR:  c_res = a | b;
         OP_XOR: c_res = a ^ b;
         OP_NOT: c_res = ~a;
         OP_SHL: begin
            c_res   = {a[WIDTH-2:0], 1'b0};
            c_carry = a[WIDTH-1];
         end
         OP_SHR: begin
            c_res   = {1'b0, a[WIDTH-1:1]};
            c_carry = a[0];
         end
         OP_ASR: begin
            c_res   = {a[WIDTH-1], a[WIDTH-1:1]};
            c_carry = a[0];
         end
         OP_ROL: begin
            c_res   = {a[WIDTH-2:0], a[WIDTH-1]};
            c_carry = a[WIDTH-1];
         end
         OP_ROR: begin
            c_res   = {a[0], a[WIDTH-1:1]};
            c_carry = a[0];
         end
         default: begin
            c_res   = '0;
            c_carry = 1'b0;
            c_ovf   = 1'b0;
         end
      endcase
   end

   // Control FSM with registered result, flags and out_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         a_r       <= '0;
         acc_hi    <= '0;
         acc_lo    <= '0;
         cnt       <= '0;
         out_valid <= 1'b0;
         result    <= '0;
         result_hi <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
         negative  <= 1'b0;
         zero      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  if (op == OP_MUL) begin
                     a_r    <= a;
                     acc_hi <= '0;
                     acc_lo <= b;
                     cnt    <= CNT_W'(WIDTH);
                     state  <= S_MUL;
                  end else begin
                     result    <= c_res;
                     result_hi <= '0;
                     carry_out <= c_carry;
                     overflow  <= c_ovf;
                     negative  <= c_res[WIDTH-1];
                     zero      <= (c_res == '0);
                     out_valid <= 1'b1;
                     state     <= S_DONE;
                  end
               end
            end
            S_MUL: begin
               if (cnt == '0) begin
                  result    <= acc_lo;
                  result_hi <= acc_hi;
                  carry_out <= (acc_hi != '0);
                  overflow  <= 1'b0;
                  negative  <= acc_hi[WIDTH-1];
                  zero      <= ({acc_hi, acc_lo} == '0);
                  out_valid <= 1'b1;
                  state     <= S_DONE;
               end else begin
                  // Shift the running product right, pulling in the carry of the partial sum.
                  {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
                  cnt              <= cnt - CNT_W'(1);
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq
module tb_alu_seq;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a_i;
   logic [7:0] b_i;
   logic [3:0] op_i;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] result;
   logic [7:0] result_hi;
   logic       carry_out;
   logic       overflow;
   logic       negative;
   logic       zero;
   logic       busy;

   int total;
   int bad;

   alu_seq #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a_i),
      .b         (b_i),
      .op        (op_i),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .result_hi (result_hi),
      .carry_out (carry_out),
      .overflow  (overflow),
      .negative  (negative),
      .zero      (zero),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // flags order: {carry, overflow, negative, zero}
   task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] op, input logic [7:0] exp_res,
                         input logic [7:0] exp_hi, input logic [3:0] exp_flags,
                         input int exp_lat, input int hold);
      int n;
      logic hs_err;
      logic hold_err;
      logic [7:0] snap_res;
      logic [3:0] snap_flags;
      @(negedge clk);
      check({tag, " in_ready"}, 32'(in_ready), 32'd1);
      a_i       = a;
      b_i       = b;
      op_i      = op;
      in_valid  = 1'b1;
      out_ready = (hold == 0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a_i      = ~a;
      b_i      = ~b;
      op_i     = op ^ 4'h5;
      n        = 0;
      hs_err   = 1'b0;
      if (in_ready || !busy) hs_err = 1'b1;
      while (!out_valid && n < 40) begin
         @(posedge clk);
         #1;
         n++;
         if (in_ready || !busy) hs_err = 1'b1;
      end
      check({tag, " latency"}, 32'(n), 32'(exp_lat));
      check({tag, " busy"}, 32'(hs_err), 32'd0);
      check({tag, " result"}, 32'(result), 32'(exp_res));
      check({tag, " result_hi"}, 32'(result_hi), 32'(exp_hi));
      check({tag, " flags"}, 32'({carry_out, overflow, negative, zero}), 32'(exp_flags));
      snap_res   = result;
      snap_flags = {carry_out, overflow, negative, zero};
      hold_err   = 1'b0;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         if (!out_valid || in_ready || result != snap_res ||
             {carry_out, overflow, negative, zero} != snap_flags) hold_err = 1'b1;
      end
      if (hold > 0) check({tag, " hold"}, 32'(hold_err), 32'd0);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check({tag, " release"}, 32'({out_valid, in_ready}), 32'b01);
   endtask

   initial begin
      logic seen;
      total     = 0;
      bad       = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a_i       = '0;
      b_i       = '0;
      op_i      = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("reset in_ready", 32'(in_ready), 32'd1);
      check("reset outs", 32'({out_valid, busy, carry_out, overflow, negative, zero}), 32'd0);
      check("reset result", 32'({result_hi, result}), 32'd0);

      run_op("add_ff_01", 8'hFF, 8'h01, 4'd0, 8'h00, 8'h00, 4'b1001, 0, 0);
      run_op("add_7f_01", 8'h7F, 8'h01, 4'd0, 8'h80, 8'h00, 4'b0110, 0, 0);
      run_op("sub_80_01", 8'h80, 8'h01, 4'd1, 8'h7F, 8'h00, 4'b0100, 0, 0);
      run_op("sub_03_05", 8'h03, 8'h05, 4'd1, 8'hFE, 8'h00, 4'b1010, 0, 0);
      run_op("or_zero",   8'h00, 8'h00, 4'd3, 8'h00, 8'h00, 4'b0001, 0, 0);
      run_op("xor",       8'hAA, 8'hFF, 4'd4, 8'h55, 8'h00, 4'b0000, 0, 0);
      run_op("not",       8'h00, 8'h12, 4'd5, 8'hFF, 8'h00, 4'b0010, 0, 0);
      run_op("shl",       8'hC0, 8'h00, 4'd6, 8'h80, 8'h00, 4'b1010, 0, 0);
      run_op("shr",       8'h01, 8'h00, 4'd7, 8'h00, 8'h00, 4'b1001, 0, 0);
      run_op("mul_ff_ff", 8'hFF, 8'hFF, 4'd8, 8'h01, 8'hFE, 4'b1010, 9, 0);
      run_op("mul_0d_0b", 8'h0D, 8'h0B, 4'd8, 8'h8F, 8'h00, 4'b0000, 9, 0);
      run_op("mul_zero",  8'h00, 8'h5A, 4'd8, 8'h00, 8'h00, 4'b0001, 9, 2);
      run_op("rol",       8'h81, 8'h00, 4'd10, 8'h03, 8'h00, 4'b1000, 0, 0);
      run_op("ror_bp",    8'h01, 8'h00, 4'd11, 8'h80, 8'h00, 4'b1010, 0, 5);

      // Abort a multiply with a one-cycle reset pulse at iteration 4.
      @(negedge clk);
      a_i       = 8'h05;
      b_i       = 8'h03;
      op_i      = 4'd8;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort outs", 32'({out_valid, busy, in_ready, carry_out, overflow, negative, zero}), 32'd0);
      check("abort result", 32'({result_hi, result}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen  = 1'b0;
      repeat (15) begin
         @(posedge clk);
         #1;
         if (out_valid || busy) seen = 1'b1;
      end
      check("abort no valid", 32'(seen), 32'd0);

      run_op("and_f0_3c", 8'hF0, 8'h3C, 4'd2, 8'h30, 8'h00, 4'b0000, 0, 0);
      run_op("asr_81",    8'h81, 8'h00, 4'd9, 8'hC0, 8'h00, 4'b1010, 0, 0);
      run_op("rsvd_13",   8'hFF, 8'hFF, 4'd13, 8'h00, 8'h00, 4'b0001, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
